// File: rtl/variable_pkg.sv
// Shared types for the role arbiter: FSM state encoding and named role indices.
package variable_pkg;

  typedef enum logic [1:0] {
    SELECT  = 2'd0,
    CLAIMED = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  localparam int PLAYER_1 = 0;
  localparam int PLAYER_2 = 1;

endpackage

// File: rtl/role_arbiter.sv
// Two-board role arbiter: claim a role locally, wait for the remote board to
// hold a different role for a stable window, then lock. Same-role conflicts
// are resolved by the IS_MASTER side keeping its claim.
module role_arbiter
  import variable_pkg::*;
#(
  parameter int NUM_ROLES      = 2,
  parameter int IS_MASTER      = 0,
  parameter int CONFIRM_CYCLES = 1024,
  localparam int ROLE_W        = (NUM_ROLES > 2) ? $clog2(NUM_ROLES) : 1
) (
  input  logic                 clk60MHz,
  input  logic                 rst,
  input  logic [NUM_ROLES-1:0] role_choose,
  input  logic                 release_req,
  input  logic [NUM_ROLES-1:0] remote_claim,
  output logic [NUM_ROLES-1:0] local_claim,
  output logic [NUM_ROLES-1:0] role_led,
  output logic [ROLE_W-1:0]    current_role,
  output logic                 role_valid,
  output logic                 locked
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES) + 1;

  state_e               state_q;
  logic [NUM_ROLES-1:0] claim_q;
  logic [ROLE_W-1:0]    role_q;
  logic                 valid_q;
  logic                 locked_q;
  logic [CNT_W-1:0]     cnt_q;

  // Roles we may take: pressed, not held remotely, not already ours.
  // In SELECT claim_q is zero, so the same vector serves the initial claim.
  logic [NUM_ROLES-1:0] avail;
  logic [ROLE_W-1:0]    pick_idx;
  logic                 pick_any;
  logic                 conflict;
  logic                 remote_none;

  assign avail       = role_choose & ~remote_claim & ~claim_q;
  assign pick_any    = |avail;
  assign conflict    = (|claim_q) && (remote_claim == claim_q);
  assign remote_none = (remote_claim == '0);

  // Lowest-set-bit encoder over the available roles.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_ROLES - 1; i >= 0; i--) begin
      if (avail[i]) pick_idx = ROLE_W'(i);
    end
  end

  // Arbiter FSM. The confirm counter runs up to CONFIRM_CYCLES, so the lock
  // lands exactly CONFIRM_CYCLES+1 cycles after CONFIRM is entered and the
  // counter never needs to wrap.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q  <= SELECT;
      claim_q  <= '0;
      role_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else if (release_req) begin
      state_q  <= SELECT;
      claim_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        SELECT: begin
          if (pick_any) begin
            claim_q <= NUM_ROLES'(1) << pick_idx;
            role_q  <= pick_idx;
            valid_q <= 1'b1;
            state_q <= CLAIMED;
          end
        end
        CLAIMED: begin
          if (conflict) begin
            if (IS_MASTER == 0) begin
              claim_q <= '0;
              valid_q <= 1'b0;
              state_q <= SELECT;
            end
          end else if (pick_any) begin
            claim_q <= NUM_ROLES'(1) << pick_idx;
            role_q  <= pick_idx;
          end else if (!remote_none) begin
            cnt_q   <= '0;
            state_q <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (conflict) begin
            cnt_q <= '0;
            if (IS_MASTER != 0) begin
              state_q <= CLAIMED;
            end else begin
              claim_q <= '0;
              valid_q <= 1'b0;
              state_q <= SELECT;
            end
          end else if (remote_none) begin
            cnt_q   <= '0;
            state_q <= CLAIMED;
          end else if (cnt_q == CNT_W'(CONFIRM_CYCLES)) begin
            locked_q <= 1'b1;
            state_q  <= LOCKED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          state_q <= LOCKED;
        end
        default: state_q <= SELECT;
      endcase
    end
  end

  assign local_claim  = claim_q;
  assign role_led     = claim_q;
  assign current_role = role_q;
  assign role_valid   = valid_q;
  assign locked       = locked_q;

endmodule
